digital_clock_core: RTL and testbench
=====================================

// Module: digital_clock_core
// PURPOSE
//   Parametrised, fully synchronous successor to the six-digit wall clock: keeps HH:MM:SS as BCD
//   registers on one clock, with a configurable tick prescaler, debounced push-button adjust,
//   a seconds/minutes/hours set-mode FSM and 12h/24h display.
//   No derived clocks or ripple counters.
//   BCD outputs drive the existing 7-segment decoders directly; no divide/modulus stage is needed.
// PARAMETERS
//   TICK_DIV         50_000_000  i_clk cycles per one-second tick; minimum 2
//   DEBOUNCE_CYCLES  1_000_000   cycles the synchronised button must be stable before it is accepted; minimum 1
//   MODE_12H         0           0 = 24h display 00-23; 1 = 12h display 12,01-11 with o_pm
// PORTS
//   i_clk        in   1  system clock; all state changes on its rising edge
//   i_rst_n      in   1  synchronous reset, active-low
//   i_set_sec    in   1  set-seconds switch, async, level
//   i_set_min    in   1  set-minutes switch, async, level
//   i_set_hr     in   1  set-hours switch, async, level
//   i_btn_n      in   1  raw push-button, async, active-low (pressed = 0)
//   o_sec_lo     out  4  BCD seconds units
//   o_sec_hi     out  4  BCD seconds tens
//   o_min_lo     out  4  BCD minutes units
//   o_min_hi     out  4  BCD minutes tens
//   o_hr_lo      out  4  BCD hours units (display form)
//   o_hr_hi      out  4  BCD hours tens (display form)
//   o_pm         out  1  1 when internal hour >= 12; 0 always when MODE_12H = 0
//   o_tick       out  1  one-cycle pulse per accepted one-second tick
//   o_day_pulse  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
// BEHAVIOUR
//   Reset (i_rst_n = 0 at edge)
//     - Time 00:00:00; FSM = RUN; prescaler = 0; debounce counter = 0.
//     - Debounced button = released; sync flops = 1.
//     - o_tick = o_day_pulse = 0; o_pm = 0.
//     - Display = 00:00:00 in 24h mode, 12:00:00 in 12h mode.
//     - Reset mid-adjust or mid-debounce discards all pending state.
//   FSM: states RUN, SET_SEC, SET_MIN, SET_HR
//     - Next state is decoded each cycle from the 2-flop-synchronised switches.
//     - Priority: hr > min > sec; no switch set selects RUN.
//   Prescaler
//     - Counts 0..TICK_DIV-1 in RUN only; tick fires when count = TICK_DIV-1, then count wraps to 0.
//     - Held at 0 outside RUN, so the first tick after returning to RUN comes exactly TICK_DIV cycles later.
//   Button
//     - Path: 2-flop sync -> stable-count debounce -> edge detect.
//     - A press event is a one-cycle pulse on the debounced 1->0 transition. Release produces no event.
//     - Holding the button produces exactly one event; there is no auto-repeat.
//     - A glitch shorter than DEBOUNCE_CYCLES produces no event.
//   Update (priority: reset > press/tick)
//     - RUN, tick: sec+1. 59 -> 00 carries min+1. min 59 -> 00 carries hr+1. hr 23 -> 00.
//     - At 23:59:59 the tick produces 00:00:00 and pulses o_day_pulse in that same cycle.
//     - SET_SEC, press: sec+1, 59 -> 00, no carry.
//     - SET_MIN, press: min+1, 59 -> 00, no carry.
//     - SET_HR, press: hr+1, 23 -> 00.
//     - A press event in RUN is ignored. Ticks never occur outside RUN.
//     - A press is applied using the state register value of the same cycle, even if the switches change in that cycle.
//   Arithmetic
//     - Each digit is a 4-bit BCD counter: units wrap 9 -> 0 with carry.
//     - sec_hi/min_hi wrap 5 -> 0; hour pair wraps 23 -> 00.
//     - Registers never hold non-BCD values.
//   Display
//     - Outputs are combinational from the time registers; zero added latency.
//     - 12h conversion: hr 00 -> 12 (o_pm = 0); 01-11 unchanged (o_pm = 0).
//     - 12h conversion: 12 -> 12 (o_pm = 1); 13-23 -> 01-11 (o_pm = 1).
//     - Internal time is always kept as 24h.
//   o_tick is registered and is high in the same cycle the seconds register changes.
// TESTING (TICK_DIV=4, DEBOUNCE_CYCLES=3)
//   1. Reset, then 60 ticks in RUN -> reads 00:01:00; o_tick period = 4 cycles; first tick 4 cycles after reset release.
//   2. Preload 23:59:59, one tick -> 00:00:00; o_day_pulse high for exactly 1 cycle.
//   3. i_set_min=1, 3 clean presses held 10 cycles each -> min +3, sec/hr unchanged, no ticks; press at 59 -> 00, hr unchanged.
//   4. Button low for 2 cycles (glitch) -> no change; low for 10 cycles -> exactly one increment.
//   5. MODE_12H=1, set hr 00, 12, 13, 23 -> display 12/pm0, 12/pm1, 01/pm1, 11/pm1.
//   6. i_rst_n=0 for 1 cycle while in SET_HR with a debounce in progress -> 00:00:00, RUN, no stray increment afterwards.

Source files
------------

// File: rtl/digital_clock_core.sv
// Six-digit BCD wall clock on a single clock: tick prescaler, debounced adjust button,
// seconds/minutes/hours set-mode FSM and optional 12h display conversion.
module digital_clock_core #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit MODE_12H        = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_set_sec,
    input  logic       i_set_min,
    input  logic       i_set_hr,
    input  logic       i_btn_n,
    output logic [3:0] o_sec_lo,
    output logic [3:0] o_sec_hi,
    output logic [3:0] o_min_lo,
    output logic [3:0] o_min_hi,
    output logic [3:0] o_hr_lo,
    output logic [3:0] o_hr_hi,
    output logic       o_pm,
    output logic       o_tick,
    output logic       o_day_pulse
);

    localparam int                  PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam int                  DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HR} clkState_t;

    clkState_t          state, nextState;
    logic [2:0]         swSync_p0, swSync_p1;
    logic               btnSync_p0, btnSync_p1;
    logic               btnDb_p2, btnDbPrev_p3;
    logic [DB_W-1:0]    dbCnt;
    logic               pressEvent;
    logic [PRESC_W-1:0] prescCnt;
    logic               tickNow;
    logic [3:0]         secLo, secHi, minLo, minHi, hrLo, hrHi;
    logic               tickReg, dayReg;
    logic [7:0]         dispHr;

    function automatic logic [3:0] digitNext(input logic [3:0] d, input logic [3:0] last);
        return (d == last) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] hourNext(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == 4'd2 && lo == 4'd3)
            return 8'h00;
        else if (lo == 4'd9)
            return {hi + 4'd1, 4'd0};
        else
            return {hi, lo + 4'd1};
    endfunction

    // 24h BCD hour to 12h BCD hour: 00 -> 12, 13..23 -> 01..11
    function automatic logic [7:0] hourTo12h(input logic [3:0] hi, input logic [3:0] lo);
        case (hi)
            4'd0:    return (lo == 4'd0) ? 8'h12 : {hi, lo};
            4'd1:    return (lo >= 4'd3) ? {4'd0, lo - 4'd2} : {hi, lo};
            default: return (lo < 4'd2) ? {4'd0, lo + 4'd8} : {4'd1, lo - 4'd2};
        endcase
    endfunction

    // Stage p0/p1: two-flop synchronisers for switches and button
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            swSync_p0  <= 3'b000;
            swSync_p1  <= 3'b000;
            btnSync_p0 <= 1'b1;
            btnSync_p1 <= 1'b1;
        end else begin
            swSync_p0  <= {i_set_hr, i_set_min, i_set_sec};
            swSync_p1  <= swSync_p0;
            btnSync_p0 <= i_btn_n;
            btnSync_p1 <= btnSync_p0;
        end
    end

    // Stage p2/p3: stable-count debounce, then falling-edge detect
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btnDb_p2     <= 1'b1;
            btnDbPrev_p3 <= 1'b1;
            dbCnt        <= '0;
        end else begin
            btnDbPrev_p3 <= btnDb_p2;
            if (btnSync_p1 == btnDb_p2) begin
                dbCnt <= '0;
            end else if (dbCnt == DB_LAST) begin
                btnDb_p2 <= btnSync_p1;
                dbCnt    <= '0;
            end else begin
                dbCnt <= dbCnt + 1'b1;
            end
        end
    end

    assign pressEvent = btnDbPrev_p3 & ~btnDb_p2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= RUN;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = RUN;
        if (swSync_p1[2])
            nextState = SET_HR;
        else if (swSync_p1[1])
            nextState = SET_MIN;
        else if (swSync_p1[0])
            nextState = SET_SEC;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            prescCnt <= '0;
        else if (state != RUN || prescCnt == PRESC_LAST)
            prescCnt <= '0;
        else
            prescCnt <= prescCnt + 1'b1;
    end

    assign tickNow = (state == RUN) && (prescCnt == PRESC_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            secLo   <= 4'd0;
            secHi   <= 4'd0;
            minLo   <= 4'd0;
            minHi   <= 4'd0;
            hrLo    <= 4'd0;
            hrHi    <= 4'd0;
            tickReg <= 1'b0;
            dayReg  <= 1'b0;
        end else begin
            tickReg <= 1'b0;
            dayReg  <= 1'b0;
            if (tickNow) begin
                tickReg <= 1'b1;
                secLo   <= digitNext(secLo, 4'd9);
                if (secLo == 4'd9) begin
                    secHi <= digitNext(secHi, 4'd5);
                    if (secHi == 4'd5) begin
                        minLo <= digitNext(minLo, 4'd9);
                        if (minLo == 4'd9) begin
                            minHi <= digitNext(minHi, 4'd5);
                            if (minHi == 4'd5) begin
                                {hrHi, hrLo} <= hourNext(hrHi, hrLo);
                                dayReg       <= (hrHi == 4'd2) && (hrLo == 4'd3);
                            end
                        end
                    end
                end
            end else if (pressEvent) begin
                case (state)
                    SET_SEC: begin
                        secLo <= digitNext(secLo, 4'd9);
                        if (secLo == 4'd9)
                            secHi <= digitNext(secHi, 4'd5);
                    end
                    SET_MIN: begin
                        minLo <= digitNext(minLo, 4'd9);
                        if (minLo == 4'd9)
                            minHi <= digitNext(minHi, 4'd5);
                    end
                    SET_HR:  {hrHi, hrLo} <= hourNext(hrHi, hrLo);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dispHr = {hrHi, hrLo};
        if (MODE_12H)
            dispHr = hourTo12h(hrHi, hrLo);
    end

    assign o_sec_lo    = secLo;
    assign o_sec_hi    = secHi;
    assign o_min_lo    = minLo;
    assign o_min_hi    = minHi;
    assign o_hr_hi     = dispHr[7:4];
    assign o_hr_lo     = dispHr[3:0];
    assign o_pm        = MODE_12H && ((hrHi == 4'd2) || (hrHi == 4'd1 && hrLo >= 4'd2));
    assign o_tick      = tickReg;
    assign o_day_pulse = dayReg;

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench for digital_clock_core: a 24h and a 12h instance share all inputs;
// expected times are hand-computed BCD constants.
module tb_digital_clock_core;

    logic       clk = 1'b0;
    logic       rstN;
    logic       setSec, setMin, setHr, btnN;
    logic [3:0] secLo, secHi, minLo, minHi, hrLo, hrHi;
    logic [3:0] secLo12, secHi12, minLo12, minHi12, hrLo12, hrHi12;
    logic       pm, tick, dayPulse, pm12, tick12, dayPulse12;
    logic [23:0] time24, time12;

    int checkCnt = 0;
    int passCnt  = 0;
    int tickCount = 0;
    int dayCount  = 0;

    always #5 clk = ~clk;

    digital_clock_core #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .MODE_12H(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_set_sec(setSec), .i_set_min(setMin),
        .i_set_hr(setHr), .i_btn_n(btnN),
        .o_sec_lo(secLo), .o_sec_hi(secHi), .o_min_lo(minLo), .o_min_hi(minHi),
        .o_hr_lo(hrLo), .o_hr_hi(hrHi), .o_pm(pm), .o_tick(tick), .o_day_pulse(dayPulse)
    );

    digital_clock_core #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .MODE_12H(1'b1)) dut12 (
        .i_clk(clk), .i_rst_n(rstN), .i_set_sec(setSec), .i_set_min(setMin),
        .i_set_hr(setHr), .i_btn_n(btnN),
        .o_sec_lo(secLo12), .o_sec_hi(secHi12), .o_min_lo(minLo12), .o_min_hi(minHi12),
        .o_hr_lo(hrLo12), .o_hr_hi(hrHi12), .o_pm(pm12), .o_tick(tick12), .o_day_pulse(dayPulse12)
    );

    assign time24 = {hrHi, hrLo, minHi, minLo, secHi, secLo};
    assign time12 = {hrHi12, hrLo12, minHi12, minLo12, secHi12, secLo12};

    always @(negedge clk) begin
        if (tick)     tickCount++;
        if (dayPulse) dayCount++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp)
            passCnt++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pressBtn(input int hold);
        btnN = 1'b0;
        repeat (hold) @(negedge clk);
        btnN = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic pressN(input int n);
        repeat (n) pressBtn(10);
    endtask

    // Pulses reset for one edge; returns at the negedge with reset released.
    task automatic pulseReset();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    // Cycles (sampled at negedge) until o_tick is seen; 0 if not within budget.
    task automatic waitTick(input int budget, output int cyc);
        cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (tick) begin
                cyc = c;
                break;
            end
        end
    endtask

    int firstC, lastC, cyc, ticks, periodErr, tickBase, dayBase;

    initial begin
        rstN = 1'b0; setSec = 1'b0; setMin = 1'b0; setHr = 1'b0; btnN = 1'b1;
        repeat (3) @(negedge clk);

        checkVal("rst_time24", time24, 24'h000000);
        checkVal("rst_tick", tick, 0);
        checkVal("rst_day", dayPulse, 0);
        checkVal("rst_pm24", pm, 0);
        checkVal("rst_time12", time12, 24'h120000);
        checkVal("rst_pm12", pm12, 0);

        // 60 ticks in RUN
        rstN = 1'b1;
        waitTick(20, firstC);
        checkVal("first_tick_cycle", firstC, 4);
        checkVal("first_tick_time", time24, 24'h000001);
        ticks = (firstC != 0) ? 1 : 0;
        lastC = firstC;
        periodErr = 0;
        for (int c = firstC + 1; c <= firstC + 400 && ticks < 60; c++) begin
            @(negedge clk);
            if (tick) begin
                if (c - lastC != 4) periodErr++;
                lastC = c;
                ticks++;
            end
        end
        checkVal("tick_count_60", ticks, 60);
        checkVal("tick_period_err", periodErr, 0);
        checkVal("run_60_time24", time24, 24'h000100);
        checkVal("run_60_time12", time12, 24'h120100);

        // Preload 23:59:59 through set modes; 12h checks on the way
        setHr = 1'b1;
        pulseReset();
        repeat (6) @(negedge clk);
        tickBase = tickCount;
        checkVal("sethr_entry", time24, 24'h000000);
        pressN(12);
        checkVal("hr12_time24", time24, 24'h120000);
        checkVal("hr12_time12", time12, 24'h120000);
        checkVal("hr12_pm12", pm12, 1);
        checkVal("hr12_pm24", pm, 0);
        pressN(1);
        checkVal("hr13_time12", time12, 24'h010000);
        checkVal("hr13_pm12", pm12, 1);
        pressN(10);
        checkVal("hr23_time24", time24, 24'h230000);
        checkVal("hr23_time12", time12, 24'h110000);
        checkVal("hr23_pm12", pm12, 1);
        checkVal("hr23_pm24", pm, 0);

        setHr = 1'b0; setMin = 1'b1;
        repeat (6) @(negedge clk);
        pressN(3);
        checkVal("min_plus3", time24, 24'h230300);
        checkVal("no_tick_in_set", tickCount - tickBase, 0);
        pressBtn(40);
        checkVal("min_hold_once", time24, 24'h230400);
        pressN(55);
        checkVal("min_59", time24, 24'h235900);
        pressN(1);
        checkVal("min_wrap", time24, 24'h230000);
        pressN(59);
        checkVal("min_59_again", time24, 24'h235900);

        setMin = 1'b0; setSec = 1'b1;
        repeat (6) @(negedge clk);
        btnN = 1'b0;
        repeat (2) @(negedge clk);
        btnN = 1'b1;
        repeat (12) @(negedge clk);
        checkVal("glitch_ignored", time24, 24'h235900);
        pressBtn(10);
        checkVal("press_after_glitch", time24, 24'h235901);
        pressN(58);
        checkVal("sec_59", time24, 24'h235959);
        checkVal("no_tick_in_set_all", tickCount - tickBase, 0);

        // Back to RUN: midnight rollover
        dayBase = dayCount;
        setSec = 1'b0;
        waitTick(20, cyc);
        checkVal("rollover_seen", (cyc != 0), 1);
        checkVal("rollover_time", time24, 24'h000000);
        checkVal("day_pulse_at_tick", dayPulse, 1);
        repeat (10) @(negedge clk);
        checkVal("day_pulse_once", dayCount - dayBase, 1);

        // Reset while in SET_HR with a debounce in progress
        setHr = 1'b1;
        repeat (6) @(negedge clk);
        btnN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b0; setHr = 1'b0; btnN = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        checkVal("rst_mid_adjust_time", time24, 24'h000000);
        waitTick(20, firstC);
        checkVal("post_rst_first_tick", firstC, 4);
        checkVal("post_rst_time", time24, 24'h000001);
        repeat (16) @(negedge clk);
        checkVal("post_rst_no_stray", time24, 24'h000005);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
